// File: rtl/lector_banco.sv
// lector_banco: read-side sequencer for the 16x32 register bank.
//
// It walks a register index range [start_addr .. end_addr], which wraps
// modulo 2**ADDR_W. For each index it drives the bank read address A1,
// waits one cycle for the combinational RD1 to settle, and captures the
// word. It then presents the word with its index on a valid/ready stream.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 one-cycle scan request, ignored while busy
//   abort                 synchronous scan cancel, wins over start/handshake
//   start_addr, end_addr  scan range, sampled together with start
//   A1 / RD1              bank read address out / read data in
//   out_data, out_addr    captured word and its register index
//   out_valid, out_ready  output stream handshake
//   busy                  scan in progress
//   done                  one-cycle pulse after the last word is accepted
//   dbg_state             current FSM state (IDLE=0, READ=1, SEND=2)
//
// Handshake: a word moves when out_valid and out_ready are both 1 at a
// rising edge. While out_valid=1 and out_ready=0, out_data and out_addr
// hold. out_valid never drops without a transfer, except on abort or reset.
module lector_banco #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   end_reg, end_reg_nxt;
  logic [ADDR_W-1:0]   a1_nxt;
  logic [DATA_W-1:0]   out_data_nxt;
  logic [ADDR_W-1:0]   out_addr_nxt;
  logic                out_valid_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      end_reg   <= '0;
      A1        <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      end_reg   <= end_reg_nxt;
      A1        <= a1_nxt;
      out_data  <= out_data_nxt;
      out_addr  <= out_addr_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    end_reg_nxt   = end_reg;
    a1_nxt        = A1;
    out_data_nxt  = out_data;
    out_addr_nxt  = out_addr;
    out_valid_nxt = out_valid;
    busy_nxt      = busy;
    // done is a pulse. It is high for a single cycle after the IDLE entry edge.
    done_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        // Abort in IDLE has no effect, except that it blocks a
        // simultaneous start.
        if (start && !abort) begin
          a1_nxt      = start_addr;
          end_reg_nxt = end_addr;
          busy_nxt    = 1'b1;
          state_nxt   = READ;
        end
      end

      READ: begin
        if (abort) begin
          out_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else begin
          // RD1 has had a full cycle to settle on the address driven last edge.
          out_data_nxt  = RD1;
          out_addr_nxt  = A1;
          out_valid_nxt = 1'b1;
          state_nxt     = SEND;
        end
      end

      SEND: begin
        if (abort) begin
          out_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          if (A1 == end_reg) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            // Natural overflow gives the modulo-2**ADDR_W wrap.
            a1_nxt    = A1 + ADDR_W'(1);
            state_nxt = READ;
          end
        end
      end

      default: begin
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lector_banco.sv
// Self-checking bench for lector_banco. A behavioural bank model feeds RD1.
// Expected words come from the scan range rules and the bank contents.
module tb_lector_banco;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [ADDR_W-1:0] A1;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] bank [NREG];
  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic              hold_chk = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_addr;

  lector_banco #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr),
    .A1(A1), .RD1(RD1),
    .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and bank model.
  always #5 clk = ~clk;
  assign RD1 = bank[A1];

  // Scoreboard monitor. It samples on the falling edge, when inputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (hold_chk) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_data || out_addr !== hold_addr) begin
          errors++;
          $display("FAIL hold: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                   out_valid, out_addr, out_data, hold_addr, hold_data);
        end
      end
      hold_chk  = out_valid && !out_ready && !abort;
      hold_data = out_data;
      hold_addr = out_addr;
      if (out_valid && out_ready && !abort) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got addr=%0d data=%h, required no word", out_addr, out_data);
        end else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          if ({out_addr, out_data} !== e) begin
            errors++;
            $display("FAIL word: got addr=%0d data=%h, required addr=%0d data=%h",
                     out_addr, out_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  // Reference model: indices from s up to e, inclusive, modulo NREG.
  task automatic expect_range(input int s, input int e);
    int n;
    n = ((e - s + NREG) % NREG) + 1;
    for (int k = 0; k < n; k++) begin
      int a;
      a = (s + k) % NREG;
      exp_q.push_back({ADDR_W'(a), bank[a]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one scan. mode 0: always ready. mode 1: random ready, pct percent.
  // mode 2: stall 3 cycles on the second word. Returns when done is seen.
  task automatic run_scan(input int s, input int e, input int mode, input int pct,
                          output int cyc);
    int stall;
    stall = 0;
    expect_range(s, e);
    start = 1'b1;
    start_addr = ADDR_W'(s);
    end_addr = ADDR_W'(e);
    out_ready = (mode == 1) ? ($urandom_range(0, 99) < pct) : 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (A1 !== ADDR_W'(s) || busy !== 1'b1) begin
      errors++;
      $display("FAIL scan_start: A1=%0d busy=%b, required A1=%0d busy=1", A1, busy, s);
    end
    cyc = 0;
    while (cyc < 400) begin
      if (mode == 1) out_ready = ($urandom_range(0, 99) < pct);
      else if (mode == 2 && out_valid && out_addr == ADDR_W'((s + 1) % NREG) && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else out_ready = 1'b1;
      tick();
      cyc++;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_end: done=%b busy=%b valid=%b after %0d cycles, required done=1 busy=0 valid=0",
               done, busy, out_valid, cyc);
    end
  endtask

  // Lets the done pulse expire, then checks pulse count and scoreboard drain.
  task automatic settle(input int exp_done, input string name);
    out_ready = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: done=%b, required 0", name, done);
    end
    tick();
    checks++;
    if (done_cnt != exp_done || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: done_cnt=%0d left=%0d busy=%b, required done_cnt=%0d left=0 busy=0",
               name, done_cnt, exp_q.size(), busy, exp_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (A1 !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_data !== '0 || out_addr !== '0) begin
      errors++;
      $display("FAIL reset: A1=%0d valid=%b busy=%b done=%b addr=%0d data=%h, required all 0",
               A1, out_valid, busy, done, out_addr, out_data);
    end
  endtask

  task automatic test_single();
    int cyc;
    bank[9] = 32'd7;
    done_cnt = 0;
    run_scan(9, 9, 0, 100, cyc);
    settle(1, "single");
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int i = 0; i < NREG; i++) bank[i] = DATA_W'(i * 16);
    done_cnt = 0;
    run_scan(2, 4, 2, 100, cyc);
    settle(1, "backpressure");
  endtask

  task automatic test_wrap_r15();
    int cyc;
    bank[14] = 32'd5;
    bank[15] = 32'h0000_0100;
    bank[0]  = 32'hA;
    done_cnt = 0;
    run_scan(14, 0, 0, 100, cyc);
    settle(1, "wrap");
  endtask

  task automatic test_full_scan();
    int cyc;
    for (int i = 0; i < NREG; i++) bank[i] = $urandom;
    done_cnt = 0;
    run_scan(1, 0, 0, 100, cyc);
    checks++;
    if (cyc != 32) begin
      errors++;
      $display("FAIL full_latency: done after %0d cycles, required 32", cyc);
    end
    settle(1, "full");
  endtask

  task automatic test_abort();
    logic restarted, aborted;
    int cyc;
    restarted = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < NREG; i++) bank[i] = $urandom;
    done_cnt = 0;
    expect_range(0, 4);
    start = 1'b1;
    start_addr = '0;
    end_addr = 4'd15;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 100 && !aborted) begin
      start = 1'b0;
      if (out_valid && out_addr == 4'd3 && !restarted) begin
        start = 1'b1;
        start_addr = 4'd7;
        end_addr = 4'd7;
        restarted = 1'b1;
      end
      if (out_valid && out_addr == 4'd5) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      tick();
      abort = 1'b0;
      start = 1'b0;
      cyc++;
    end
    checks++;
    if (!aborted || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: reached=%b valid=%b busy=%b, required reached=1 valid=0 busy=0",
               aborted, out_valid, busy);
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_final: done_cnt=%0d left=%0d, required 0 and 0", done_cnt, exp_q.size());
    end
    // Abort and start together in IDLE: the scan must not start.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b valid=%b, required 0 and 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < NREG; i++) bank[i] = $urandom;
    done_cnt = 0;
    run_scan(5, 7, 0, 100, cyc);
    // Start is raised during the done cycle and must be accepted.
    run_scan(12, 13, 0, 100, cyc);
    settle(2, "b2b");
  endtask

  task automatic test_random();
    int cyc;
    for (int it = 0; it < 8; it++) begin
      int s, e;
      for (int i = 0; i < NREG; i++) bank[i] = $urandom;
      s = $urandom_range(0, NREG - 1);
      e = $urandom_range(0, NREG - 1);
      done_cnt = 0;
      run_scan(s, e, 1, $urandom_range(30, 90), cyc);
      settle(1, "random");
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    for (int i = 0; i < NREG; i++) bank[i] = $urandom | 32'h1;
    done_cnt = 0;
    start = 1'b1;
    start_addr = 4'd3;
    end_addr = 4'd8;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!(cyc < 10) || A1 !== '0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || out_data !== '0 || out_addr !== '0) begin
      errors++;
      $display("FAIL async_reset: cyc=%0d A1=%0d valid=%b busy=%b done=%b data=%h, required all 0",
               cyc, A1, out_valid, busy, done, out_data);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after: done_cnt=%0d busy=%b, required 0 and 0", done_cnt, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) bank[i] = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_wrap_r15();
    test_full_scan();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
